// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
package adder_arb_pkg;

    localparam int WIDTH_DEF = 10;

    // Response buffer occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Adder result at the default width: carry-out above the sum bits
    typedef struct packed {
        logic                 carry;
        logic [WIDTH_DEF-1:0] sum;
    } result_t;

endpackage

// File: rtl/shared_adder.sv
// Single shared WIDTH-bit adder; purely combinational, returns carry and sum.
module shared_adder #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // Zero-extend both operands so the top bit is the carry-out
    always_comb begin
        {carry, sum} = {1'b0, a} + {1'b0, b};
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ requesters, with a
// single-entry registered response buffer.
// Optional build macro: ADDER_RR_ARBITER_SATURATE_EN (clamp sum to all-ones on carry).
//
// state | meaning
// ------+--------------------------------------------
// EMPTY | response buffer holds nothing, rsp_valid=0
// FULL  | response buffer holds a result, rsp_valid=1
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_carry,
    output logic [IDW-1:0]        rsp_id
);

    // One extra bit so prio_ptr + offset never overflows before the wrap
    localparam int PW = IDW + 1;

    state_t           st, st_nxt;
    logic [IDW-1:0]   prio_ptr, ptr_nxt;
    logic [IDW-1:0]   grant_idx;
    logic             grant_found;
    logic [PW-1:0]    cand_w;
    logic [IDW-1:0]   cand;
    logic             can_accept;
    logic             xfer;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;
    logic [WIDTH-1:0] res_sum;

    assign rsp_valid  = (st == FULL);
    assign can_accept = (st == EMPTY) | rsp_ready;

    // Search req_valid starting at prio_ptr, wrapping modulo NREQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_w      = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_w = {1'b0, prio_ptr} + PW'(k);
            if (cand_w >= PW'(NREQ)) begin
                cand_w = cand_w - PW'(NREQ);
            end
            cand = cand_w[IDW-1:0];
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Grant only when the buffer can take a result and reset is not active
    always_comb begin
        xfer      = grant_found & can_accept & ~rst;
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Route the granted requester's operands onto the shared adder
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    shared_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a     (a_sel),
        .b     (b_sel),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Optional clamp; carry still reports the overflow either way
    always_comb begin
`ifdef ADDER_RR_ARBITER_SATURATE_EN
        res_sum = add_carry ? '1 : add_sum;
`else
        res_sum = add_sum;
`endif
    end

    // Pointer moves to the slot after the winner
    always_comb begin
        ptr_nxt = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Buffer occupancy next-state: load on transfer, drain when consumed
    always_comb begin
        st_nxt = st;
        case (st)
            EMPTY: if (xfer) st_nxt = FULL;
            FULL:  if (rsp_ready && !xfer) st_nxt = EMPTY;
            default: st_nxt = EMPTY;
        endcase
    end

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= EMPTY;
        end else begin
            st <= st_nxt;
        end
    end

    // Response data and priority pointer update only on a transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
            prio_ptr  <= '0;
        end else if (xfer) begin
            rsp_sum   <= res_sum;
            rsp_carry <= add_carry;
            rsp_id    <= grant_idx;
            prio_ptr  <= ptr_nxt;
        end
    end

endmodule

// File: doc/adder_rr_arbiter.md
# adder_rr_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit adder among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants at most one requester per cycle, drives the shared adder, and returns the registered sum, carry and requester ID through a single-entry response buffer with valid/ready backpressure. It sits between several adder clients and one `shared_adder` instance, so the datapath is never duplicated.

## Interface
Parameters:
- WIDTH, 10, operand and sum width.
- NREQ, 4, number of requesters; must be ≥ 2.
- IDW, $clog2(NREQ), requester ID width (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant, one-hot or zero; combinational.
- req_a  input  NREQ*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B, same packing.
- rsp_valid  output  1  response buffer holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_sum  output  WIDTH  registered sum.
- rsp_carry  output  1  registered carry-out (bit WIDTH of A+B).
- rsp_id  output  IDW  index of the requester that produced the response.

## Operation
- States: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = !rsp_valid | rsp_ready.
- Grant:
  - When can_accept, search req_valid starting from prio_ptr, wrapping modulo NREQ.
  - The first valid index g gets req_ready[g]=1. All other bits are 0.
  - If no request is valid, or can_accept=0, req_ready is all 0.
- Transfer happens on req_valid[g] & req_ready[g]:
  - Buffer loads {rsp_carry, rsp_sum} = req_a[g] + req_b[g] (WIDTH+1-bit result, zero-extended operands).
  - rsp_id=g, rsp_valid=1.
  - prio_ptr = (g+1) mod NREQ.
- Response drains on rsp_valid & rsp_ready. If no new transfer occurs in that cycle, rsp_valid goes to 0 and data holds its stale value.
- Simultaneous drain and transfer in one cycle: the buffer reloads with the new result and rsp_valid stays 1 (back-to-back, one result per cycle).
- Stall (FULL & !rsp_ready): req_ready all 0, rsp_* held stable, prio_ptr unchanged.
- prio_ptr advances only on a transfer. Idle cycles do not move it.
- Requesters may drop req_valid at any time before a grant. There is no stickiness requirement.

## Timing
- Latency is 1 cycle: a transfer at edge N means the response is visible after edge N.
- Throughput is 1 op/cycle when rsp_ready is held high.
- Reset values: rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, prio_ptr=0.
- req_ready=0 in every cycle where rst=1.
- Reset mid-operation: a pending response is discarded and is not delivered. The next grant starts at requester 0.
- Wrap-around: a sum overflowing WIDTH bits sets rsp_carry=1, and rsp_sum holds the low WIDTH bits. Example for WIDTH=10: 1023+1 gives carry=1, sum=0.

## Configuration
- ADDER_RR_ARBITER_SATURATE_EN
  - Defined: when the carry-out is 1, rsp_sum is forced to all-ones (1023 for WIDTH=10) and rsp_carry still reports 1.
  - Undefined: modular sum as described in Operation.
- Timing and handshake are identical in both builds.

## Structure
- Package `adder_arb_pkg`:
  - WIDTH default constant.
  - State typedef enum {EMPTY, FULL}.
  - Result struct typedef {carry, sum}.
- Sub-module `shared_adder`: purely combinational WIDTH-bit adder returning {carry, sum}. This is the single shared datapath.
- Round-robin search, prio_ptr and the response buffer live in the top module.

## Test plan
- Reset check: hold rst=1 for 3 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0 throughout.
- Single request, then overflow:
  - Only req 2 valid with a=5, b=7, rsp_ready=1 -> next cycle rsp_valid=1, id=2, sum=12, carry=0.
  - Then a=1023, b=1 -> sum=0, carry=1 (saturating build: sum=1023, carry=1).
- Round-robin fairness: all 4 requesters continuously valid, rsp_ready=1 -> grant order 0,1,2,3,0,... and each ID appears once per 4 responses.
- Backpressure:
  - Hold rsp_ready=0 after one response -> req_ready=0 and rsp_* stable for 5 cycles.
  - Raise rsp_ready -> a drain and a new transfer complete in the same cycle, and rsp_valid stays 1.
- Pointer skip: prio_ptr=1, only req 0 and req 3 valid -> req 3 granted first, then req 0.
- Mid-operation reset: assert rst while rsp_valid=1 and rsp_ready=0 -> response is lost, and the next grant goes to the lowest valid index starting from 0.
